// File: rtl/systolic_array_ws_pipe.sv
// Weight-stationary systolic MAC array, y[c] = sum_r x[r]*W[r][c], with weight-load/compute/drain job control.
// Latency: out_valid rises ROWS+COLS cycles after the accepting edge of each activation vector.
// Backpressure: out_valid & !out_ready freezes every skew/PE/deskew/output register and drops in_ready.
module systolic_array_ws_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int ROWS       = 10,
    parameter int COLS       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [15:0]                num_vec,
    output logic                       busy,
    output logic                       done,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_WIDTH-1:0]  out_data
);
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int L  = ROWS + COLS;

    typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;
    state_t state, state_nxt;

    logic [15:0]   num_q;
    logic [15:0]   cnt_in;
    logic [15:0]   cnt_out;
    logic [CW-1:0] cnt_w;
    logic          busy_nxt;
    logic          done_nxt;

    logic stall, adv;
    logic w_fire, in_fire, out_fire;
    logic last_w, last_in, last_out;
    logic start_ok;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign w_ready  = (state == LOAD_W);
    assign in_ready = (state == COMPUTE) & ~stall;
    assign w_fire   = w_valid & w_ready;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign last_w   = (cnt_w == CW'(ROWS - 1));
    assign last_in  = ((cnt_in + 16'd1) == num_q);
    assign last_out = ((cnt_out + 16'd1) == num_q);
    assign start_ok = (state == IDLE) && start && (num_vec != 16'd0);

    always_comb begin
        state_nxt = state;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = LOAD_W;
                    busy_nxt  = 1'b1;
                end
            end
            LOAD_W: begin
                if (w_fire && last_w) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                if (in_fire && last_in) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_fire && last_out) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            num_q   <= '0;
            cnt_w   <= '0;
            cnt_in  <= '0;
            cnt_out <= '0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            if (start_ok) begin
                num_q   <= num_vec;
                cnt_w   <= '0;
                cnt_in  <= '0;
                cnt_out <= '0;
            end
            if (w_fire)   cnt_w   <= cnt_w + CW'(1);
            if (in_fire)  cnt_in  <= cnt_in + 16'd1;
            if (out_fire) cnt_out <= cnt_out + 16'd1;
        end
    end

    // Stationary weights; loading is independent of output backpressure.
    logic [DATA_WIDTH-1:0] w_reg [ROWS][COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    w_reg[r][c] <= '0;
        end else if (w_fire) begin
            for (int c = 0; c < COLS; c++)
                w_reg[cnt_w][c] <= w_data[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // x_fwd[r][c] is the activation entering PE(r,c); psum[r][c] is PE(r,c)'s registered sum.
    logic [DATA_WIDTH-1:0] x_fwd   [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  psum    [ROWS][COLS];
    logic [ACC_WIDTH-1:0]  col_out [COLS];
    logic [COLS*ACC_WIDTH-1:0] out_nxt;
    logic [L-1:0]          vpipe;

    // Row r sees its element r+1 edges after accept: one capture stage plus r skew stages.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        logic [DATA_WIDTH-1:0] sk [r+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) sk[i] <= '0;
            end else if (adv) begin
                sk[0] <= in_fire ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int i = 1; i <= r; i++) sk[i] <= sk[i-1];
            end
        end
        assign x_fwd[r][0] = sk[r];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe
            logic [ACC_WIDTH-1:0]          ps_in;
            logic [ACC_WIDTH-1:0]          ps_q;
            logic signed [2*DATA_WIDTH-1:0] xs, ws, prod;

            if (r == 0) begin : g_top
                assign ps_in = '0;
            end else begin : g_mid
                assign ps_in = psum[r-1][c];
            end

            assign xs   = (2*DATA_WIDTH)'($signed(x_fwd[r][c]));
            assign ws   = (2*DATA_WIDTH)'($signed(w_reg[r][c]));
            assign prod = xs * ws;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   ps_q <= '0;
                else if (adv) ps_q <= ps_in + ACC_WIDTH'(prod);
            end
            assign psum[r][c] = ps_q;

            if (c < COLS - 1) begin : g_xreg
                logic [DATA_WIDTH-1:0] x_q;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)   x_q <= '0;
                    else if (adv) x_q <= x_fwd[r][c];
                end
                assign x_fwd[r][c+1] = x_q;
            end
        end
    end

    // Column c finishes c cycles after column 0; pad the early ones so all columns align.
    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign col_out[c] = psum[ROWS-1][c];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] dq [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) dq[i] <= '0;
                end else if (adv) begin
                    dq[0] <= psum[ROWS-1][c];
                    for (int i = 1; i < D; i++) dq[i] <= dq[i-1];
                end
            end
            assign col_out[c] = dq[D-1];
        end
        assign out_nxt[c*ACC_WIDTH +: ACC_WIDTH] = col_out[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (adv) begin
            vpipe     <= {vpipe[L-2:0], in_fire};
            out_valid <= vpipe[L-1];
            out_data  <= out_nxt;
        end
    end
endmodule

// File: doc/systolic_array_ws_pipe.md
Name: systolic_array_ws_pipe

Overview:
Parametrised, self-contained weight-stationary systolic MAC array with handshaked weight load, input skew, output deskew and a job-control FSM. It computes y[c] = sum over r of x[r]*W[r][c] for a stream of ROWS-element activation vectors and returns one aligned COLS-element result vector per input vector. It is the next-generation drop-in compute core for the NICE CNN accelerator datapath.

Parameters:
DATA_WIDTH, 8, signed operand width for weights and activations
ACC_WIDTH, 32, signed partial-sum and result width
ROWS, 10, array rows (activation vector length), >=1
COLS, 5, array columns (result vector length), >=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job start pulse, sampled only in IDLE
num_vec  in  16  vectors in the job, sampled with start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the last result is accepted
w_valid  in  1  weight row valid
w_ready  out  1  high in LOAD_W
w_data  in  COLS*DATA_WIDTH  weight row; W[row][c] at [c*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  1  activation vector valid
in_ready  out  1  activation accept
in_data  in  ROWS*DATA_WIDTH  x[r] at [r*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  result valid
out_ready  in  1  result accept
out_data  out  COLS*ACC_WIDTH  y[c] at [c*ACC_WIDTH +: ACC_WIDTH]

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). Reset clears all outputs to 0, the FSM to IDLE, all weight, skew, pipeline and deskew registers to 0, all in-flight valid bits, and all counters. Reset mid-job abandons the job silently, with no done pulse.
- FSM states:
  - IDLE: start=1 with num_vec!=0 latches num_vec and goes to LOAD_W. start with num_vec==0 is ignored.
  - LOAD_W: w_ready=1. Each w_valid&w_ready beat writes row cnt_w (0..ROWS-1). After beat ROWS-1, go to COMPUTE.
  - COMPUTE: in_ready = !stall. Each accepted vector increments cnt_in. After the accept where cnt_in reaches num_vec, go to DRAIN.
  - DRAIN: in_ready=0. When out_valid&out_ready completes result number num_vec, pulse done for 1 cycle, drop busy and go to IDLE.
- start outside IDLE is ignored. w_valid is ignored outside LOAD_W. in_valid is ignored outside COMPUTE.
- Dataflow:
  - The skew delays x[r] and its valid bit by r cycles.
  - PE(r,c) registers x to the right and psum downward.
  - The psum input of row 0 is 0.
  - Deskew delays column c by COLS-1-c.
  - A final output register holds out_data and out_valid.
- Latency: out_valid for vector k rises exactly L=ROWS+COLS cycles after its accepting edge, absent stalls.
- Ordering and bubbles: results return in input order. Cycles without an accept carry valid=0 and produce no output.
- Stall: stall = out_valid & !out_ready. While stalled, every skew, PE, deskew and output register holds, and in_ready=0. Nothing is lost or duplicated. out_data is stable while out_valid=1 and !out_ready.
- Arithmetic: the full signed DATA_WIDTH x DATA_WIDTH product is sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH with no saturation and no overflow flag.
- Weights persist after a job, but each job reloads all ROWS rows.
- Simultaneous events: the result handshake on the same cycle as a new output arrives is a normal pipeline advance with no bubble. done and busy deassert on the cycle after the final out handshake edge.

Test Plan:
- Defaults; all W=1; x[r]=r+1; num_vec=1 -> w_ready for 10 beats; out_valid 15 cycles after accept; every y[c]=55; done one cycle; busy low.
- Signed: W[0][0]=-128, x[0]=-128, all else 0 -> y[0]=16384, y[1..4]=0.
- 4 back-to-back vectors x=k*1 (k=1..4), all W=1, out_ready low 3 cycles at the first out_valid -> in_ready low during stall; results 10,20,30,40 in order; out_data stable while stalled; one done.
- Wrap: ACC_WIDTH=16, all W=127, all x=127 -> y[c]=30218 (161290 mod 65536).
- Control: start with num_vec=0 -> busy stays 0. start during COMPUTE -> ignored, job completes with the original num_vec. ROWS=2, COLS=3 instance -> latency 5.
- Reset asserted mid-COMPUTE with 3 vectors in flight -> all outputs 0 immediately. A new job with fresh weights yields only correct new results, with no stale out_valid.
